// File: rtl/ascon_perm_engine.sv
// Ascon permutation engine: applies p^12, p^8 or p^6 to a 320-bit state,
// UNROLL rounds per clock, with valid/ready handshakes on input and output.
// Lane packing: x0 = [319:256], x1 = [255:192], x2 = [191:128],
//               x3 = [127:64],  x4 = [63:0].
module ascon_perm_engine #(
    parameter int UNROLL  = 1,
    parameter int OUT_REG = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [319:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] state_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] RI_END     = 4'd12;
    localparam logic [3:0] RI_STEP    = 4'(UNROLL);
    localparam logic       OUT_REG_EN = (OUT_REG != 0);

    // Only 1 and 2 divide every round count (6, 8, 12).
    generate
        if ((UNROLL != 1) && (UNROLL != 2)) begin : g_bad_unroll
            $error("ascon_perm_engine: UNROLL must be 1 or 2");
        end
    endgenerate

    // Round constant for round index 0..11; out-of-range indices give 0.
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'hf0;
            4'd1:    c = 8'he1;
            4'd2:    c = 8'hd2;
            4'd3:    c = 8'hc3;
            4'd4:    c = 8'hb4;
            4'd5:    c = 8'ha5;
            4'd6:    c = 8'h96;
            4'd7:    c = 8'h87;
            4'd8:    c = 8'h78;
            4'd9:    c = 8'h69;
            4'd10:   c = 8'h5a;
            4'd11:   c = 8'h4b;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // First round index for the selected permutation (12 - R); 11 maps to p^12.
    function automatic logic [3:0] start_index(input logic [1:0] m);
        logic [3:0] idx;
        case (m)
            2'b01:   idx = 4'd4;
            2'b10:   idx = 4'd6;
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    // One Ascon round: constant addition, bitsliced S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2 = x2 ^ {56'd0, c};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
        x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
        x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
        x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
        x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
        return {x0, x1, x2, x3, x4};
    endfunction

    logic [1:0]   fsm_r;
    logic [1:0]   fsm_nxt_s;
    logic [3:0]   ri_r;
    logic [319:0] st_r;
    logic [319:0] round_s;
    logic         accept_s;
    logic         step_s;
    logic         last_step_s;
    logic         copy_s;

    assign accept_s    = (fsm_r == ST_IDLE) && in_valid;
    // ri == 12 while BUSY only happens with an output register: that cycle copies the result.
    assign step_s      = (fsm_r == ST_BUSY) && (ri_r != RI_END);
    assign copy_s      = (fsm_r == ST_BUSY) && (ri_r == RI_END);
    assign last_step_s = step_s && ((ri_r + RI_STEP) == RI_END);

    assign in_ready  = (fsm_r == ST_IDLE);
    assign out_valid = (fsm_r == ST_DONE);

    // Apply UNROLL consecutive rounds to the state register.
    always_comb begin
        logic [319:0] acc;
        acc = st_r;
        for (int u = 0; u < UNROLL; u++) begin
            acc = ascon_round(acc, round_const(ri_r + 4'(u)));
        end
        round_s = acc;
    end

    // Next-state decode for IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            ST_IDLE: begin
                if (in_valid) fsm_nxt_s = ST_BUSY;
                else          fsm_nxt_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (copy_s)                           fsm_nxt_s = ST_DONE;
                else if (last_step_s && !OUT_REG_EN)  fsm_nxt_s = ST_DONE;
                else                                  fsm_nxt_s = ST_BUSY;
            end
            ST_DONE: begin
                if (out_ready) fsm_nxt_s = ST_IDLE;
                else           fsm_nxt_s = ST_DONE;
            end
            default: fsm_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state and round index registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_r <= ST_IDLE;
            ri_r  <= 4'd0;
        end else begin
            fsm_r <= fsm_nxt_s;
            if (accept_s)    ri_r <= start_index(mode);
            else if (step_s) ri_r <= ri_r + RI_STEP;
            else             ri_r <= ri_r;
        end
    end

    // State register: loaded on accept, updated once per BUSY step.
    always_ff @(posedge CLK) begin
        if (RST)           st_r <= 320'd0;
        else if (accept_s) st_r <= state_in;
        else if (step_s)   st_r <= round_s;
        else               st_r <= st_r;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [319:0] out_r;
            // Output register: captures the finished state on the BUSY -> DONE copy cycle.
            always_ff @(posedge CLK) begin
                if (RST)         out_r <= 320'd0;
                else if (copy_s) out_r <= st_r;
                else             out_r <= out_r;
            end
            assign state_out = out_r;
        end else begin : g_out_direct
            assign state_out = st_r;
        end
    endgenerate

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench for ascon_perm_engine: two instances (UNROLL=1/OUT_REG=1 and
// UNROLL=2/OUT_REG=0) checked against a table-driven Ascon model.
module tb_ascon_perm_engine;

    typedef struct {
        logic [319:0] exp;
        int           acc;
        int           lat;
    } sb_t;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic         CLK;
    logic         RST;
    logic         in_valid_a  [2];
    logic         in_ready_a  [2];
    logic [1:0]   mode_a      [2];
    logic [319:0] state_in_a  [2];
    logic         out_valid_a [2];
    logic         out_ready_a [2];
    logic [319:0] state_out_a [2];

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;
    sb_t q0[$];
    sb_t q1[$];
    bit  prev_v [2];
    int  vstart [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            ascon_perm_engine #(
                .UNROLL ((g == 0) ? 1 : 2),
                .OUT_REG((g == 0) ? 1 : 0)
            ) u_dut (
                .CLK      (CLK),
                .RST      (RST),
                .in_valid (in_valid_a[g]),
                .in_ready (in_ready_a[g]),
                .mode     (mode_a[g]),
                .state_in (state_in_a[g]),
                .out_valid(out_valid_a[g]),
                .out_ready(out_ready_a[g]),
                .state_out(state_out_a[g])
            );
        end
    endgenerate

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int rounds(input logic [1:0] m);
        if (m == 2'b01)      return 8;
        else if (m == 2'b10) return 6;
        else                 return 12;
    endfunction

    function automatic int exp_lat(input int d, input logic [1:0] m);
        if (d == 0) return rounds(m) + 1;
        else        return rounds(m) / 2;
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference permutation: per-column S-box table lookup, constant c[i] = {15-i, i}.
    function automatic logic [319:0] model_perm(input logic [319:0] s, input logic [1:0] m);
        logic [63:0] x [5];
        logic [63:0] t [5];
        logic [4:0]  v;
        int r;
        r = rounds(m);
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int i = 12 - r; i < 12; i++) begin
            x[2][7:0] = x[2][7:0] ^ 8'((15 - i) * 16 + i);
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                v = SBOX[v];
                for (int k = 0; k < 5; k++) x[k][j] = v[4 - k];
            end
            t[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
            t[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
            t[2] = x[2] ^ rr(x[2], 1)  ^ rr(x[2], 6);
            t[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
            t[4] = x[4] ^ rr(x[4], 7)  ^ rr(x[4], 41);
            for (int k = 0; k < 5; k++) x[k] = t[k];
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int qsz(input int d);
        if (d == 0) return q0.size();
        else        return q1.size();
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int d, input sb_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Present one state; record the expectation when the accept edge is certain.
    task automatic send(input int d, input logic [1:0] m, input logic [319:0] s,
                        input bit hold, output int acc);
        sb_t e;
        int  w;
        mode_a[d]     = m;
        state_in_a[d] = s;
        in_valid_a[d] = 1'b1;
        w = 0;
        acc = -1;
        while (in_ready_a[d] !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_accept_timeout: got in_ready=0 for %0d cycles expected 1", d, w);
            in_valid_a[d] = 1'b0;
        end else begin
            e.exp = model_perm(s, m);
            e.acc = cyc + 1;
            e.lat = exp_lat(d, m);
            acc   = e.acc;
            push(d, e);
            tick();
            if (!hold) begin
                in_valid_a[d] = 1'b0;
                mode_a[d]     = 2'($urandom);
                state_in_a[d] = rnd320();
            end
        end
    endtask

    task automatic drain(input int d);
        int w = 0;
        while (qsz(d) != 0 && w < 300) begin
            tick();
            w++;
        end
        if (w >= 300) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_drain_timeout: got %0d results pending expected 0", d, qsz(d));
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge CLK) begin
        sb_t e;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid_a[d] === 1'b1) begin
                    if (!prev_v[d]) vstart[d] = cyc;
                    chk($sformatf("dut%0d_in_ready_while_done", d), {319'd0, in_ready_a[d]}, 320'd0);
                    if (qsz(d) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dut%0d_unexpected_result: got out_valid=1 expected no pending result", d);
                    end else begin
                        if (d == 0) e = q0[0];
                        else        e = q1[0];
                        chk($sformatf("dut%0d_state_out", d), state_out_a[d], e.exp);
                        if (out_ready_a[d] === 1'b1) begin
                            chk($sformatf("dut%0d_latency", d), 320'(vstart[d] - e.acc), 320'(e.lat));
                            if (d == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                        end
                    end
                end
                prev_v[d] = (out_valid_a[d] === 1'b1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [319:0] s;
        logic [1:0]   m;
        int acc, a0, a1, prev_acc, prev_lat, w;

        RST = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid_a[d]  = 1'b0;
            mode_a[d]      = 2'b00;
            state_in_a[d]  = 320'd0;
            out_ready_a[d] = 1'b1;
        end
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Idle after reset
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d_rst_in_ready", d),  {319'd0, in_ready_a[d]},  320'd1);
                chk($sformatf("dut%0d_rst_out_valid", d), {319'd0, out_valid_a[d]}, 320'd0);
                chk($sformatf("dut%0d_rst_state_out", d), state_out_a[d], 320'd0);
            end
        end
        mon_en = 1'b1;
        tick();

        // Ascon-128 initialisation state, key = 0, nonce = 0
        for (int d = 0; d < 2; d++) begin
            send(d, 2'b00, {64'h80400c0600000000, 256'd0}, 1'b0, acc);
            drain(d);
        end

        // All modes on random states, plus mode 11 against mode 00 on one state
        for (int d = 0; d < 2; d++) begin
            for (int mi = 0; mi < 4; mi++) begin
                for (int r = 0; r < 3; r++) begin
                    send(d, 2'(mi), rnd320(), 1'b0, acc);
                    drain(d);
                end
            end
            s = rnd320();
            send(d, 2'b00, s, 1'b0, acc);
            drain(d);
            send(d, 2'b11, s, 1'b0, acc);
            drain(d);
        end

        // Backpressure with ignored in_valid pulses
        for (int d = 0; d < 2; d++) begin
            out_ready_a[d] = 1'b0;
            send(d, 2'($urandom_range(0, 3)), rnd320(), 1'b0, acc);
            w = 0;
            while (out_valid_a[d] !== 1'b1 && w < 100) begin
                tick();
                w++;
            end
            if (w >= 100) begin
                checks++;
                failures++;
                $display("FAIL dut%0d_valid_timeout: got out_valid=0 for %0d cycles expected 1", d, w);
            end
            for (int c = 0; c < 20; c++) begin
                if (c >= 5 && c < 10) begin
                    in_valid_a[d] = 1'b1;
                    mode_a[d]     = 2'($urandom);
                    state_in_a[d] = rnd320();
                end else begin
                    in_valid_a[d] = 1'b0;
                end
                tick();
            end
            in_valid_a[d]  = 1'b0;
            out_ready_a[d] = 1'b1;
            drain(d);
            chk($sformatf("dut%0d_idle_after_backpressure", d), {319'd0, in_ready_a[d]}, 320'd1);
        end

        // Reset on the third BUSY edge of a p^12, then p^6 on a zero state
        fork
            send(0, 2'b00, rnd320(), 1'b0, a0);
            send(1, 2'b00, rnd320(), 1'b0, a1);
        join
        tick();
        tick();
        RST = 1'b1;
        q0.delete();
        q1.delete();
        tick();
        RST = 1'b0;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_abort_in_ready", d),  {319'd0, in_ready_a[d]},  320'd1);
            chk($sformatf("dut%0d_abort_out_valid", d), {319'd0, out_valid_a[d]}, 320'd0);
            chk($sformatf("dut%0d_abort_state_out", d), state_out_a[d], 320'd0);
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            send(d, 2'b10, 320'd0, 1'b0, acc);
            drain(d);
        end

        // Back-to-back with in_valid and out_ready held high
        for (int d = 0; d < 2; d++) begin
            prev_acc = 0;
            prev_lat = 0;
            for (int i = 0; i < 100; i++) begin
                m = 2'($urandom_range(0, 3));
                send(d, m, rnd320(), 1'b1, acc);
                if (i > 0) chk($sformatf("dut%0d_interval", d), 320'(acc - prev_acc), 320'(prev_lat + 2));
                prev_acc = acc;
                prev_lat = exp_lat(d, m);
            end
            in_valid_a[d] = 1'b0;
            drain(d);
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ascon_perm_engine.md
Name: ascon_perm_engine

Overview:
- Iterative Ascon permutation engine: applies p^12, p^8 or p^6 to a 320-bit state, UNROLL rounds per clock.
- valid/ready handshake on both sides; input and output state are registered.
- Generalised successor of the fixed single-configuration encrypt top. Shared datapath for the team's next Ascon-128/128a AEAD and hash controllers.

Parameters:
- UNROLL, 1, rounds per clock; legal values 1 or 2 (both divide 6, 8 and 12). Any other value is a synthesis-time error.
- OUT_REG, 1, 1 = state_out driven from a dedicated output register; 0 = state_out driven directly from the state register.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- in_valid  input  1  state_in and mode are valid.
- in_ready  output  1  engine can accept a new state.
- mode  input  2  00 = p^12, 01 = p^8, 10 = p^6, 11 = treated as p^12.
- state_in  input  320  x0 = [319:256], x1 = [255:192], x2 = [191:128], x3 = [127:64], x4 = [63:0].
- out_valid  output  1  state_out holds the permuted result.
- out_ready  input  1  consumer accepts the result.
- state_out  output  320  permuted state, same lane packing as state_in.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a rising edge: latch state_in into the state register.
  - Set round index ri = 12 - R, where R = 12, 8 or 6 from mode.
  - Go to BUSY.
- BUSY:
  - Each cycle apply UNROLL rounds, using constants c[ri], c[ri+1], …; then ri += UNROLL.
  - When ri reaches 12 after the update, go to DONE.
- DONE:
  - out_valid = 1; state_out is stable.
  - On out_ready at the edge: go to IDLE.
  - No new input is accepted until the next cycle (in_ready = 0 in DONE).
- Round constants c[0..11]: f0, e1, d2, c3, b4, a5, 96, 87, 78, 69, 5a, 4b. Each is XORed into bits [7:0] of x2.
- Round structure, in this order: constant addition, then 5-bit S-box per bit slice, then linear layer.
  - S-box (x0 is the MSB of the 5-bit value): 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
  - Linear layer, rotate-right amounts: x0 19/28, x1 61/39, x2 1/6, x3 10/17, x4 7/41.
- Latency:
  - Accept edge at cycle k gives out_valid = 1 from cycle k + R/UNROLL + OUT_REG.
  - UNROLL = 1: p^12 = 12, p^8 = 8, p^6 = 6 BUSY cycles.
  - UNROLL = 2: half of each.
- OUT_REG = 1: result is copied to the output register on the BUSY→DONE transition, adding one cycle. state_out holds its value in IDLE and BUSY until the next result.
- Throughput: one permutation per R/UNROLL + OUT_REG + 2 cycles, assuming out_ready is held high.
- mode and state_in are sampled only at the accept edge. Changes afterwards have no effect.
- Reset (RST high at an edge, any state, including mid-BUSY):
  - Go to IDLE; ri = 0.
  - State and output registers cleared to 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, state_out = 0.
  - An in-flight permutation is discarded with no partial output.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored (not queued).
- out_valid, once asserted, stays high and state_out stays stable until the handshake completes.

Test Plan:
- Reset, then idle 5 cycles → in_ready = 1, out_valid = 0, state_out = 0 on every cycle.
- UNROLL = 1, mode = 00, state_in = {80400c0600000000, key = 0, nonce = 0} (Ascon-128 init) → out_valid exactly 12 + OUT_REG cycles after accept. Result bit-exact vs the team's C golden model.
- mode = 01 and mode = 10 on random states, both UNROLL values → first constant used is b4 (p^8) and 96 (p^6). Latencies are 8/6 (UNROLL 1) and 4/3 (UNROLL 2). Results bit-exact vs model. mode = 11 gives results identical to mode = 00.
- Backpressure: out_ready held low 20 cycles after out_valid, with in_valid pulsed meanwhile → state_out stable, in_ready = 0 throughout, no extra permutation started.
- RST asserted at BUSY cycle 3 of a p^12 → next cycle IDLE, all outputs 0. A following p^6 on an all-zero state matches the model, with no corruption from the aborted run.
- Back-to-back: 100 random states with in_valid and out_ready held high → 100 results in order, all matching the model, interval R/UNROLL + OUT_REG + 2 cycles.
